uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits directly behind the UART receiver. It consumes the receiver's byte strobe, data and error pulse, and sequences the bytes into length-prefixed, checksummed command frames. Payload bytes stream out as they arrive. Each frame ends with a single completion pulse and an ok/error status, which downstream command decode uses to accept or discard the buffered payload.

---
 rtl/uart_rx_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: SOF, length, payload, checksum.
// Streams payload bytes and reports one completion pulse with ok/error status per frame.
module uart_rx_frame_ctrl #(
  parameter longint CLK_FREQ      = 100_000_000,
  parameter longint BAUD_RATE     = 115200,
  parameter logic [7:0] SOF_BYTE  = 8'hA5,
  parameter int     MAX_LEN       = 64,
  parameter int     TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rvld,
  input  logic [7:0]  rdata,
  input  logic        uart_err,
  input  logic        err_clr,
  output logic        pvld,
  output logic [7:0]  pdata,
  output logic        pfirst,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic [15:0] err_cnt,
  output logic        busy
);

  localparam int TIMEOUT_CYC = int'(longint'(TIMEOUT_BYTES) * 64'sd11 * CLK_FREQ / BAUD_RATE);
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LEN     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_CHK     = 2'd3;

  localparam logic [1:0] E_LEN     = 2'd0;
  localparam logic [1:0] E_CHK     = 2'd1;
  localparam logic [1:0] E_UART    = 2'd2;
  localparam logic [1:0] E_TIMEOUT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [7:0]    len;
  logic [7:0]    cnt;
  logic [7:0]    sum;
  logic [TW-1:0] tcnt;
  logic [7:0]    sum_next;
  logic          abort;
  logic [1:0]    abort_code;
  logic          good;
  logic          take_len;
  logic          take_pay;

  assign sum_next = sum + rdata;

  // Next state and frame outcome; uart_err outranks a byte, which outranks timeout.
  always_comb begin
    state_next = state;
    abort      = 1'b0;
    abort_code = E_LEN;
    good       = 1'b0;
    take_len   = 1'b0;
    take_pay   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rvld && rdata == SOF_BYTE) state_next = S_LEN;
      end
      default: begin
        if (uart_err) begin
          abort      = 1'b1;
          abort_code = E_UART;
        end else if (rvld) begin
          case (state)
            S_LEN: begin
              if (rdata == 8'd0 || {1'b0, rdata} > 9'(MAX_LEN)) begin
                abort      = 1'b1;
                abort_code = E_LEN;
              end else begin
                take_len   = 1'b1;
                state_next = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              take_pay = 1'b1;
              if (cnt == len - 8'd1) state_next = S_CHK;
            end
            default: begin
              if (sum_next == 8'd0) begin
                good = 1'b1;
              end else begin
                abort      = 1'b1;
                abort_code = E_CHK;
              end
              state_next = S_IDLE;
            end
          endcase
        end else if (tcnt == TW'(TIMEOUT_CYC)) begin
          abort      = 1'b1;
          abort_code = E_TIMEOUT;
        end
      end
    endcase
    if (abort) state_next = S_IDLE;
  end

  // Registered state, frame bookkeeping and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= 8'd0;
      cnt        <= 8'd0;
      sum        <= 8'd0;
      tcnt       <= '0;
      pvld       <= 1'b0;
      pdata      <= 8'd0;
      pfirst     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= 2'd0;
      err_cnt    <= 16'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next != S_IDLE);
      pvld       <= take_pay;
      pfirst     <= take_pay && (cnt == 8'd0);
      frame_done <= abort | good;
      frame_ok   <= good;
      if (abort) err_code <= abort_code;
      if (err_clr) err_cnt <= 16'd0;
      else if (abort && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      // Timer restarts on every byte and parks at zero whenever the FSM is or returns idle.
      if (state == S_IDLE || state_next == S_IDLE || rvld) tcnt <= '0;
      else tcnt <= tcnt + 1'b1;
      if (take_len) begin
        len <= rdata;
        sum <= rdata;
        cnt <= 8'd0;
      end else if (take_pay) begin
        pdata <= rdata;
        sum   <= sum_next;
        cnt   <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; clock scaled so the timeout is 440 cycles.
module tb_uart_rx_frame_ctrl;

  localparam int TO = 440;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rvld = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        uart_err = 1'b0;
  logic        err_clr = 1'b0;
  logic        pvld;
  logic [7:0]  pdata;
  logic        pfirst;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic [15:0] err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_rx_frame_ctrl #(
    .CLK_FREQ(1_152_000), .BAUD_RATE(115200), .SOF_BYTE(8'hA5),
    .MAX_LEN(64), .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .rvld(rvld), .rdata(rdata), .uart_err(uart_err),
    .err_clr(err_clr), .pvld(pvld), .pdata(pdata), .pfirst(pfirst),
    .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One byte strobe; returns 1ns after the capturing edge so registered outputs are visible.
  task automatic send(input logic [7:0] b);
    rvld = 1'b1;
    rdata = b;
    @(posedge clk);
    #1;
    rvld = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] s;
    logic       early;

    idle_cyc(3);
    check("rst_pvld", {15'd0, pvld}, 16'd0);
    check("rst_pdata", {8'd0, pdata}, 16'd0);
    check("rst_pfirst", {15'd0, pfirst}, 16'd0);
    check("rst_done", {15'd0, frame_done}, 16'd0);
    check("rst_ok", {15'd0, frame_ok}, 16'd0);
    check("rst_code", {14'd0, err_code}, 16'd0);
    check("rst_cnt", err_cnt, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    idle_cyc(2);

    // Good frame A5 03 11 22 33 97
    send(8'hA5);
    check("good_busy", {15'd0, busy}, 16'd1);
    send(8'h03);
    check("good_len_pvld", {15'd0, pvld}, 16'd0);
    send(8'h11);
    check("good_pvld0", {15'd0, pvld}, 16'd1);
    check("good_pdata0", {8'd0, pdata}, 16'h0011);
    check("good_pfirst0", {15'd0, pfirst}, 16'd1);
    send(8'h22);
    check("good_pdata1", {8'd0, pdata}, 16'h0022);
    check("good_pfirst1", {15'd0, pfirst}, 16'd0);
    send(8'h33);
    check("good_pvld2", {15'd0, pvld}, 16'd1);
    check("good_pdata2", {8'd0, pdata}, 16'h0033);
    check("good_done_early", {15'd0, frame_done}, 16'd0);
    send(8'h97);
    check("good_pvld_chk", {15'd0, pvld}, 16'd0);
    check("good_done", {15'd0, frame_done}, 16'd1);
    check("good_ok", {15'd0, frame_ok}, 16'd1);
    check("good_cnt", err_cnt, 16'd0);
    idle_cyc(1);
    check("good_done_pulse", {15'd0, frame_done}, 16'd0);
    check("good_idle_busy", {15'd0, busy}, 16'd0);

    // Bad checksum
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("badchk_pvld", {15'd0, pvld}, 16'd1);
    send(8'h98);
    check("badchk_done", {15'd0, frame_done}, 16'd1);
    check("badchk_ok", {15'd0, frame_ok}, 16'd0);
    check("badchk_code", {14'd0, err_code}, 16'd1);
    check("badchk_cnt", err_cnt, 16'd1);
    idle_cyc(1);

    // Length zero and length over MAX_LEN
    send(8'hA5); send(8'h00);
    check("len0_done", {15'd0, frame_done}, 16'd1);
    check("len0_code", {14'd0, err_code}, 16'd0);
    check("len0_cnt", err_cnt, 16'd2);
    idle_cyc(1);
    send(8'hA5); send(8'h41);
    check("len41_done", {15'd0, frame_done}, 16'd1);
    check("len41_ok", {15'd0, frame_ok}, 16'd0);
    check("len41_code", {14'd0, err_code}, 16'd0);
    check("len41_cnt", err_cnt, 16'd3);
    idle_cyc(1);

    // Maximum length frame, payload 00..3F back to back
    send(8'hA5); send(8'h40);
    s = 8'h40;
    for (int i = 0; i < 64; i++) begin
      send(8'(i));
      s = s + 8'(i);
      check("max_pdata", {8'd0, pdata}, 16'(i));
      check("max_pfirst", {15'd0, pfirst}, (i == 0) ? 16'd1 : 16'd0);
    end
    send(8'h00 - s);
    check("max_done", {15'd0, frame_done}, 16'd1);
    check("max_ok", {15'd0, frame_ok}, 16'd1);
    check("max_code_held", {14'd0, err_code}, 16'd0);
    idle_cyc(1);

    // Noise then resync
    send(8'h00); send(8'hFF); send(8'h5A);
    check("noise_pvld", {15'd0, pvld}, 16'd0);
    check("noise_busy", {15'd0, busy}, 16'd0);
    check("noise_done", {15'd0, frame_done}, 16'd0);
    send(8'hA5); send(8'h01); send(8'h7F);
    check("resync_pvld", {15'd0, pvld}, 16'd1);
    check("resync_pdata", {8'd0, pdata}, 16'h007F);
    check("resync_pfirst", {15'd0, pfirst}, 16'd1);
    send(8'h80);
    check("resync_ok", {15'd0, frame_ok}, 16'd1);
    check("resync_done", {15'd0, frame_done}, 16'd1);
    idle_cyc(1);

    // Timeout: frame_done exactly TO+1 cycles after the last byte
    send(8'hA5); send(8'h02); send(8'h11);
    early = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) early = 1'b1;
    end
    check("to_early", {15'd0, early}, 16'd0);
    check("to_busy", {15'd0, busy}, 16'd1);
    idle_cyc(1);
    check("to_done", {15'd0, frame_done}, 16'd1);
    check("to_ok", {15'd0, frame_ok}, 16'd0);
    check("to_code", {14'd0, err_code}, 16'd3);
    check("to_cnt", err_cnt, 16'd4);
    idle_cyc(1);

    // uart_err during payload drops the coincident byte
    send(8'hA5); send(8'h03); send(8'h11);
    rvld = 1'b1; rdata = 8'h22; uart_err = 1'b1;
    @(posedge clk);
    #1;
    rvld = 1'b0; uart_err = 1'b0;
    check("uerr_done", {15'd0, frame_done}, 16'd1);
    check("uerr_pvld", {15'd0, pvld}, 16'd0);
    check("uerr_code", {14'd0, err_code}, 16'd2);
    check("uerr_cnt", err_cnt, 16'd5);
    idle_cyc(1);

    // uart_err in IDLE is ignored
    uart_err = 1'b1;
    idle_cyc(1);
    uart_err = 1'b0;
    check("idle_uerr_done", {15'd0, frame_done}, 16'd0);
    check("idle_uerr_cnt", err_cnt, 16'd5);

    // err_clr alone, then coincident with an abort
    err_clr = 1'b1;
    idle_cyc(1);
    err_clr = 1'b0;
    check("clr_cnt", err_cnt, 16'd0);
    send(8'hA5); send(8'h00);
    check("clr_abort_cnt", err_cnt, 16'd1);
    idle_cyc(1);
    send(8'hA5);
    err_clr = 1'b1;
    send(8'h00);
    err_clr = 1'b0;
    check("clr_win_done", {15'd0, frame_done}, 16'd1);
    check("clr_win_cnt", err_cnt, 16'd0);
    idle_cyc(1);

    // Reset mid-payload, then a good frame
    send(8'hA5); send(8'h04); send(8'h11);
    check("mid_busy", {15'd0, busy}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_done", {15'd0, frame_done}, 16'd0);
    check("mid_rst_pvld", {15'd0, pvld}, 16'd0);
    idle_cyc(1);
    rst = 1'b0;
    idle_cyc(1);
    check("post_rst_done", {15'd0, frame_done}, 16'd0);
    send(8'hA5); send(8'h01); send(8'h7F);
    check("post_pfirst", {15'd0, pfirst}, 16'd1);
    send(8'h80);
    check("post_done", {15'd0, frame_done}, 16'd1);
    check("post_ok", {15'd0, frame_ok}, 16'd1);

    idle_cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
